// File: rtl/sw_test_status_arb.sv
// +--------------------------------------------------------------------------+
// | sw_test_status_arb: round-robin arbiter and test-lifecycle FSM for the     |
// | software test-status word. Optional watchdog: SW_TEST_STATUS_TIMEOUT_EN.   |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module sw_test_status_arb #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*32-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [31:0]            status_o,
  output logic [2:0]             state_o,
  output logic                   passed_o,
  output logic                   failed_o,
  output logic                   done_o,
  output logic                   proto_err_o,
  output logic                   timeout_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [31:0] CODE_BOOT    = 32'h0000_B090;
  localparam logic [31:0] CODE_IN_TEST = 32'h0000_4354;
  localparam logic [31:0] CODE_PASSED  = 32'h0000_900D;
  localparam logic [31:0] CODE_FAILED  = 32'h0000_BAAD;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BOOT    = 3'd1,
    S_IN_TEST = 3'd2,
    S_PASSED  = 3'd3,
    S_FAILED  = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("sw_test_status_arb: illegal NUM_REQ/CNT_W/TIMEOUT_CYCLES combination");
  end

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic [31:0]        gnt_word;
  logic               gnt_any;
  int                 sel;
  state_t             nxt_state;
  logic               err_hit;
  logic               terminal;
  logic               timeout_q;

  // First requester at or after the pointer wins.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_word = '0;
    gnt_any  = 1'b0;
    sel      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sel = (int'(ptr) + off) % NUM_REQ;
      if (!gnt_any && req_i[sel]) begin
        gnt_any      = 1'b1;
        gnt[sel]     = 1'b1;
        gnt_idx      = sel[PTR_W-1:0];
        gnt_word     = wdata_i[sel*32 +: 32];
      end
    end
  end

  assign gnt_o    = rst_ni ? gnt : '0;
  assign terminal = (state == S_PASSED) || (state == S_FAILED) || (state == S_TIMEOUT);

  always_comb begin
    nxt_state = state;
    err_hit   = 1'b0;
    case (gnt_word)
      CODE_BOOT: begin
        if (state == S_IDLE)      nxt_state = S_BOOT;
        else if (state != S_BOOT) err_hit   = 1'b1;
      end
      CODE_IN_TEST: begin
        if (state == S_BOOT)         nxt_state = S_IN_TEST;
        else if (state != S_IN_TEST) err_hit   = 1'b1;
      end
      CODE_PASSED: begin
        if (state == S_IN_TEST) nxt_state = S_PASSED;
        else                    err_hit   = 1'b1;
      end
      CODE_FAILED: nxt_state = S_FAILED;
      default: ;
    endcase
  end

`ifdef SW_TEST_STATUS_TIMEOUT_EN
  logic [CNT_W-1:0] wd;
  logic             wd_fire;

  assign wd_fire = (state == S_IN_TEST) && !gnt_any && (wd == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd <= '0;
    end else if (gnt_any || state != S_IN_TEST) begin
      wd <= '0;
    end else begin
      wd <= wd + CNT_W'(1);
    end
  end
`else
  logic wd_fire;
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr         <= '0;
      state       <= S_IDLE;
      status_o    <= '0;
      passed_o    <= 1'b0;
      failed_o    <= 1'b0;
      proto_err_o <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (gnt_any) begin
        ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
      // Terminal states still grant, but ignore the word.
      if (!terminal && gnt_any) begin
        status_o <= gnt_word;
        state    <= nxt_state;
        if (nxt_state == S_PASSED) passed_o    <= 1'b1;
        if (nxt_state == S_FAILED) failed_o    <= 1'b1;
        if (err_hit)               proto_err_o <= 1'b1;
      end else if (wd_fire) begin
        state     <= S_TIMEOUT;
        timeout_q <= 1'b1;
        failed_o  <= 1'b1;
      end
    end
  end

  assign state_o   = state;
  assign timeout_o = timeout_q;
  assign done_o    = passed_o | failed_o | timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_test_status_arb.sv
// Randomized self-checking bench for sw_test_status_arb against a rule-level model.
`default_nettype none

module tb_sw_test_status_arb;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*32-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [31:0]     status;
  logic [2:0]      state;
  logic            passed, failed, done, proto_err, timeout;

  always #5 clk = ~clk;

  sw_test_status_arb #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wdata_i(wdata), .gnt_o(gnt),
    .status_o(status), .state_o(state), .passed_o(passed), .failed_o(failed),
    .done_o(done), .proto_err_o(proto_err), .timeout_o(timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: state numbers coincide with the rank of the code that enters them.
  int          m_ptr, m_state, m_idle;
  logic [31:0] m_status;
  bit          m_pass, m_fail, m_err, m_to;

  bit          pend [N];
  logic [31:0] pword[N];

  function automatic int code_rank(input logic [31:0] w);
    case (w)
      32'h0000_B090: return 1;
      32'h0000_4354: return 2;
      32'h0000_900D: return 3;
      32'h0000_BAAD: return 4;
      default:       return 0;
    endcase
  endfunction

  function automatic int model_grant();
    for (int i = 0; i < N; i++)
      if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_state = 0; m_idle = 0; m_status = '0;
    m_pass = 0; m_fail = 0; m_err = 0; m_to = 0;
  endtask

  task automatic model_update(input int g);
    int          c;
    logic [31:0] w;
    bit          fire;
    fire = 0;
`ifdef SW_TEST_STATUS_TIMEOUT_EN
    fire = (m_state == 2) && (g < 0) && (m_idle == TO - 1);
    m_idle = (m_state == 2 && g < 0) ? m_idle + 1 : 0;
`endif
    if (g >= 0) m_ptr = (g + 1) % N;
    if (m_state >= 3) return;
    if (g >= 0) begin
      w = wdata[g*32 +: 32];
      c = code_rank(w);
      m_status = w;
      if (c == 4) begin
        m_state = 4; m_fail = 1;
      end else if (c != 0) begin
        if (c == m_state + 1) begin
          m_state = c;
          if (c == 3) m_pass = 1;
        end else if (c != m_state) begin
          m_err = 1;
        end
      end
    end else if (fire) begin
      m_state = 5; m_to = 1; m_fail = 1; m_idle = 0;
    end
  endtask

  task automatic check_outputs();
    check_eq("status", status, m_status);
    check_eq("state", {29'd0, state}, m_state);
    check_eq("flags", {27'd0, passed, failed, done, proto_err, timeout},
             {27'd0, m_pass, m_fail, m_pass | m_fail | m_to, m_err, m_to});
  endtask

  // One clock: check at the falling edge, advance model at the rising edge.
  task automatic tick(output int g);
    @(negedge clk);
    g = model_grant();
    check_eq("gnt", {28'd0, gnt}, (g < 0) ? 32'd0 : (32'd1 << g));
    check_outputs();
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '1;
    wdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check_eq("rst_gnt", {28'd0, gnt}, 32'd0);
    check_eq("rst_status", status, 32'd0);
    check_eq("rst_state", {29'd0, state}, 32'd0);
    check_eq("rst_flags", {27'd0, passed, failed, done, proto_err, timeout}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_gnt_edge", {28'd0, gnt}, 32'd0);
    rst_n = 1'b1;
    req   = '0;
    model_reset();
    for (int k = 0; k < N; k++) pend[k] = 0;
  endtask

  task automatic write1(input int k, input logic [31:0] w);
    int g;
    req = '0;
    req[k] = 1'b1;
    wdata[k*32 +: 32] = w;
    tick(g);
    req = '0;
  endtask

  task automatic idle(input int n);
    int g;
    req = '0;
    for (int i = 0; i < n; i++) tick(g);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 9))
      0, 1:    return 32'h0000_B090;
      2, 3:    return 32'h0000_4354;
      4, 5:    return 32'h0000_900D;
      6:       return 32'h0000_BAAD;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int g;
    rst_n = 1'b1;
    req   = '0;
    wdata = '0;
    model_reset();

    // Lifecycle then terminal freeze.
    do_reset();
    write1(0, 32'h0000_B090);
    write1(0, 32'h0000_4354);
    write1(0, 32'h0000_900D);
    check_eq("life_state", {29'd0, state}, 32'd3);
    check_eq("life_done", {30'd0, passed, done}, 32'd3);
    check_eq("life_status", status, 32'h0000_900D);
    write1(2, 32'h0000_BAAD);
    check_eq("freeze_status", status, 32'h0000_900D);
    check_eq("freeze_failed", {31'd0, failed}, 32'd0);
    idle(2);

    // Round-robin with all requesters held.
    do_reset();
    for (int k = 0; k < N; k++) wdata[k*32 +: 32] = 32'h1000_0000 + k;
    req = '1;
    for (int i = 0; i < 8; i++) tick(g);
    check_eq("rr_status", status, 32'h1000_0003);
    idle(1);

    // Protocol error then failure.
    do_reset();
    write1(1, 32'h0000_B090);
    write1(1, 32'h0000_900D);
    check_eq("perr_state", {29'd0, state}, 32'd1);
    check_eq("perr_flag", {31'd0, proto_err}, 32'd1);
    check_eq("perr_status", status, 32'h0000_900D);
    write1(3, 32'h0000_BAAD);
    check_eq("fail_state", {29'd0, state}, 32'd4);
    check_eq("fail_flag", {31'd0, failed}, 32'd1);
    idle(1);

    // Watchdog: expires after TO idle cycles, avoided by a write in the last one.
    do_reset();
    write1(0, 32'h0000_B090);
    write1(0, 32'h0000_4354);
    idle(TO);
`ifdef SW_TEST_STATUS_TIMEOUT_EN
    check_eq("to_state", {29'd0, state}, 32'd5);
    check_eq("to_flags", {30'd0, timeout, failed}, 32'd3);
`else
    check_eq("to_state", {29'd0, state}, 32'd2);
    check_eq("to_flags", {30'd0, timeout, failed}, 32'd0);
`endif
    do_reset();
    write1(0, 32'h0000_B090);
    write1(0, 32'h0000_4354);
    idle(TO - 1);
    write1(1, 32'h1234_5678);
    idle(TO - 2);
    check_eq("nto_state", {29'd0, state}, 32'd2);
    check_eq("nto_timeout", {31'd0, timeout}, 32'd0);
    idle(3);

    // Randomized episodes: requesters hold req and word until granted.
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        for (int k = 0; k < N; k++) begin
          if (!pend[k] && $urandom_range(0, 2) == 0) begin
            pend[k]  = 1;
            pword[k] = rand_word();
          end
          req[k] = pend[k];
          wdata[k*32 +: 32] = pend[k] ? pword[k] : $urandom;
        end
        tick(g);
        if (g >= 0) pend[g] = 0;
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
